// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART receive path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam logic RX_IDLE_LEVEL      = 1'b1;
    localparam int   DEFAULT_OVERSAMPLE = 16;
    localparam int   DEFAULT_CLK_DIV    = 27;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tick_gen.sv
// ============================================================================
//  Module   : uart_tick_gen
//  Purpose  : Divides clk down to the oversample tick; phase-resettable.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tick_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold_value,
    output logic tick
);

    localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over hold so the phase always restarts from the start edge.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold_value) begin
            if (cnt_q == CNT_LAST) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_tick_gen

`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
// ============================================================================
//  Module   : uart_rx_deserializer
//  Purpose  : Oversampling UART receiver with valid/ready output buffer.
//             Optional parity stage enabled by defining UART_RX_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  hold_value,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  frame_err,
    output logic                  overrun,
`ifdef UART_RX_PARITY_EN
    input  logic                  parity_odd,
    output logic                  parity_err,
`endif
    output logic                  busy
);

    localparam int               OS_W         = $clog2(OVERSAMPLE);
    localparam int               BC_W         = $clog2(DATA_WIDTH);
    localparam logic [OS_W-1:0]  OS_LAST      = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BC_W-1:0]  BC_LAST      = BC_W'(DATA_WIDTH - 1);

    logic                  sync1_q, sync2_q;
    logic                  rx_s;
    rx_state_t             state_q, state_d;
    logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad_q, par_bad_d;
    logic                  parity_err_q, parity_err_d;
`endif

    logic tick;
    logic tick_clear;
    logic os_wrap;
    logic mid_start;
    logic last_bit;

    assign rx_s       = sync2_q;
    assign tick_clear = (state_q == IDLE);
    assign os_wrap    = tick && (os_cnt_q == OS_LAST);
    assign mid_start  = tick && (os_cnt_q == OS_HALF_LAST);
    assign last_bit   = (bit_cnt_q == BC_LAST);

    uart_tick_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .clear      (tick_clear),
        .hold_value (hold_value),
        .tick       (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!hold_value) begin
            case (state_q)
                IDLE:      if (rx_s != RX_IDLE_LEVEL) state_d = START;
                START:     if (mid_start) state_d = (rx_s == RX_IDLE_LEVEL) ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                DATA:      if (os_wrap && last_bit) state_d = PARITY;
`else
                DATA:      if (os_wrap && last_bit) state_d = STOP;
`endif
                PARITY:    if (os_wrap) state_d = STOP;
                STOP:      if (os_wrap) state_d = (rx_s == RX_IDLE_LEVEL) ? IDLE : WAIT_IDLE;
                WAIT_IDLE: if (rx_s == RX_IDLE_LEVEL) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // The output handshake keeps running during hold; everything else freezes.
    always_comb begin
        os_cnt_d     = os_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q && !data_ready;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (!hold_value) begin
            case (state_q)
                IDLE, WAIT_IDLE: begin
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                end
                START: begin
                    if (tick) os_cnt_d = mid_start ? '0 : os_cnt_q + 1'b1;
                end
                DATA: begin
                    if (os_wrap) begin
                        os_cnt_d  = '0;
                        shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
                    end else if (tick) begin
                        os_cnt_d  = os_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick) os_cnt_d = os_wrap ? '0 : os_cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (os_wrap) par_bad_d = ((rx_s ^ (^shift_q)) != parity_odd);
`endif
                end
                STOP: begin
                    if (tick) os_cnt_d = os_wrap ? '0 : os_cnt_q + 1'b1;
                    if (os_wrap) begin
                        if (rx_s == RX_IDLE_LEVEL) begin
                            if (!data_valid_q || data_ready) begin
                                data_out_d   = shift_q;
                                data_valid_d = 1'b1;
                            end else begin
                                overrun_d    = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        // Report parity together with the word it belongs to.
                        parity_err_d = par_bad_q;
                        par_bad_d    = 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= RX_IDLE_LEVEL;
            sync2_q      <= RX_IDLE_LEVEL;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule : uart_rx_deserializer

`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
// ============================================================================
//  Module   : tb_uart_rx_deserializer
//  Purpose  : Directed self-checking bench for uart_rx_deserializer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_deserializer;

    localparam int DW      = 8;
    localparam int OS      = 16;
    localparam int CD      = 4;
    localparam int BIT_CLK = OS * CD;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR    = 1;
`else
    localparam int NPAR    = 0;
`endif
    // 2 sync flops + 1 IDLE detect, then half a start bit and all remaining bits in ticks.
    localparam int EXP_LAT = 3 + CD * (OS / 2 + OS * (DW + 1 + NPAR));

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          rx         = 1'b1;
    logic          hold_value = 1'b0;
    logic          data_ready = 1'b1;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_odd = 1'b0;
    logic          parity_err;
`endif

    uart_rx_deserializer #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS),
        .CLK_DIV    (CD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .hold_value (hold_value),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: sole writer of the running statistics.
    int            n_words = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, n_perr_load = 0, n_vcyc = 0;
    int            first_valid_cyc = 0;
    logic [DW-1:0] last_word = '0;
    logic          dv_prev = 1'b0;
    always @(negedge clk) begin
        if (data_valid) n_vcyc++;
        if (data_valid && !dv_prev) first_valid_cyc = cyc;
        if (data_valid && data_ready) begin
            n_words++;
            last_word = data_out;
        end
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) begin
            n_perr++;
            if (data_valid && !dv_prev) n_perr_load++;
        end
`endif
        dv_prev = data_valid;
    end

    int b_words, b_ferr, b_ovr, b_perr, b_perr_load, b_vcyc;
    int start_cyc;
    int n_checks = 0;
    int n_err    = 0;

    task automatic snap();
        b_words = n_words; b_ferr = n_ferr; b_ovr = n_ovr;
        b_perr = n_perr; b_perr_load = n_perr_load; b_vcyc = n_vcyc;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_clk(BIT_CLK);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ parity_odd);
`endif
        drive_bit(stop);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          stop;
        int            exp_words;
        int            exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h3C, 1'b0, 0, 1};
        vecs[4] = '{8'h81, 1'b1, 1, 0};
        vecs[5] = '{8'h01, 1'b1, 1, 0};

        reset = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(1);
        check("reset_data_out",   int'(data_out),   0);
        check("reset_data_valid", int'(data_valid), 0);
        check("reset_frame_err",  int'(frame_err),  0);
        check("reset_overrun",    int'(overrun),    0);
        check("reset_busy",       int'(busy),       0);

        // Table-driven single frames with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            snap();
            send_frame(vecs[i].data, vecs[i].stop);
            rx = 1'b1;
            wait_clk(20);
            check($sformatf("vec%0d_words", i), n_words - b_words, vecs[i].exp_words);
            check($sformatf("vec%0d_valid_cycles", i), n_vcyc - b_vcyc, vecs[i].exp_words);
            check($sformatf("vec%0d_frame_err", i), n_ferr - b_ferr, vecs[i].exp_ferr);
            check($sformatf("vec%0d_overrun", i), n_ovr - b_ovr, 0);
            if (vecs[i].exp_words == 1) begin
                check($sformatf("vec%0d_data", i), int'(last_word), int'(vecs[i].data));
                check($sformatf("vec%0d_latency", i), first_valid_cyc - start_cyc, EXP_LAT);
            end
            check($sformatf("vec%0d_busy_after", i), int'(busy), 0);
        end

        // Short glitch: false start must be rejected.
        snap();
        rx = 1'b0;
        wait_clk(10);
        check("glitch_busy_during", int'(busy), 1);
        wait_clk(10);
        rx = 1'b1;
        wait_clk(60);
        check("glitch_busy_after", int'(busy), 0);
        check("glitch_valid_cycles", n_vcyc - b_vcyc, 0);
        check("glitch_frame_err", n_ferr - b_ferr, 0);

        // Framing error followed by a break: exactly one error pulse.
        snap();
        send_frame(8'h3C, 1'b0);
        wait_clk(3 * BIT_CLK);
        check("break_busy_held", int'(busy), 1);
        rx = 1'b1;
        wait_clk(10);
        check("break_frame_err", n_ferr - b_ferr, 1);
        check("break_words", n_words - b_words, 0);
        check("break_busy_after", int'(busy), 0);
        send_frame(8'h81, 1'b1);
        wait_clk(20);
        check("break_next_words", n_words - b_words, 1);
        check("break_next_data", int'(last_word), 'h81);
        check("break_next_frame_err", n_ferr - b_ferr, 1);

        // Overrun: consumer stalled across two frames.
        snap();
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clk(20);
        check("ovr_data_valid", int'(data_valid), 1);
        check("ovr_data_out", int'(data_out), 'h11);
        check("ovr_pulses", n_ovr - b_ovr, 1);
        check("ovr_words_before", n_words - b_words, 0);
        data_ready = 1'b1;
        wait_clk(2);
        check("ovr_valid_after", int'(data_valid), 0);
        check("ovr_words_after", n_words - b_words, 1);
        check("ovr_word_taken", int'(last_word), 'h11);

        // Hold for 100 clk during data bit 3 of 0x5A; the line bit is stretched to match.
        snap();
        begin
            logic [DW-1:0] d;
            d = 8'h5A;
            @(posedge clk);
            #1;
            start_cyc = cyc;
            drive_bit(1'b0);
            for (int i = 0; i < DW; i++) begin
                if (i == 3) begin
                    rx = d[i];
                    wait_clk(10);
                    hold_value = 1'b1;
                    wait_clk(100);
                    hold_value = 1'b0;
                    wait_clk(BIT_CLK - 10);
                end else begin
                    drive_bit(d[i]);
                end
            end
`ifdef UART_RX_PARITY_EN
            drive_bit((^d) ^ parity_odd);
`endif
            drive_bit(1'b1);
        end
        wait_clk(20);
        check("hold_words", n_words - b_words, 1);
        check("hold_data", int'(last_word), 'h5A);
        check("hold_latency", first_valid_cyc - start_cyc, EXP_LAT + 100);
        check("hold_frame_err", n_ferr - b_ferr, 0);

        // Reset mid-frame, then a clean frame.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("rst_busy_before", int'(busy), 1);
        reset = 1'b1;
        rx    = 1'b1;
        wait_clk(2);
        check("rst_data_out", int'(data_out), 0);
        check("rst_data_valid", int'(data_valid), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        wait_clk(BIT_CLK + 10);
        snap();
        send_frame(8'hF0, 1'b1);
        wait_clk(20);
        check("rst_next_words", n_words - b_words, 1);
        check("rst_next_data", int'(last_word), 'hF0);
        check("rst_next_frame_err", n_ferr - b_ferr, 0);

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        snap();
        send_frame(8'h07, 1'b1);
        wait_clk(20);
        check("par_good_err", n_perr - b_perr, 0);
        check("par_good_data", int'(last_word), 'h07);
        snap();
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(((8'h07 >> i) & 8'h01) != 0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        wait_clk(20);
        check("par_bad_err", n_perr - b_perr, 1);
        check("par_bad_with_load", n_perr_load - b_perr_load, 1);
        check("par_bad_words", n_words - b_words, 1);
        check("par_bad_data", int'(last_word), 'h07);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_deserializer

`default_nettype wire
